des_round_controller: RTL and testbench

DES_ROUND_CONTROLLER -- requirements
Module: des_round_controller

---
 rtl/des_round_controller.sv | 182 ++++++++++++++++++
 tb/tb_des_round_controller.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_round_controller.sv
// des_round_controller
//
// Sequences one 16-round DES operation: initial permutation, then per round
// expansion -> S-box -> permutation (each waits for its finish flag) and a
// half swap for rounds 0..14, then the final permutation and a Done pulse.
// Every output is a flop loaded from the next-state decode, so each output
// shows the state the FSM is currently in.
//
// Configuration:
//   DES_DECRYPT_EN  defined   : Mode selects the decrypt key schedule
//                               (right rotations, zero shift in round 0).
//                   undefined : Mode is ignored and the encrypt schedule
//                               always applies; Key_Shift_Right stays 0.
//
// Ports:
//   clk                      rising-edge clock
//   rst                      synchronous active-high reset
//   Start                    start request, sampled only while idle
//   Mode                     0 = encrypt, 1 = decrypt, latched with Start
//   Expansion_Finish_Flag    expansion stage complete
//   SBox_Finish_Flag         S-box stage complete
//   Permutation_Finish_Flag  permutation stage complete
//   IP_Select .. FP_Select   stage enables, at most one high per cycle
//   Round[3:0]               current round index 0..15
//   Key_Shift_Valid          one-cycle key-schedule shift request
//   Key_Shift_Amount[1:0]    shift count, valid with Key_Shift_Valid
//   Key_Shift_Right          rotate direction, valid with Key_Shift_Valid
//   Busy                     operation in progress (INIT through FINAL)
//   Done                     one-cycle completion pulse

module des_round_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       Start,
    input  logic       Mode,
    input  logic       Expansion_Finish_Flag,
    input  logic       SBox_Finish_Flag,
    input  logic       Permutation_Finish_Flag,
    output logic       IP_Select,
    output logic       Expansion_Select,
    output logic       SBox_Select,
    output logic       Permutation_Select,
    output logic       Swap_Select,
    output logic       FP_Select,
    output logic [3:0] Round,
    output logic       Key_Shift_Valid,
    output logic [1:0] Key_Shift_Amount,
    output logic       Key_Shift_Right,
    output logic       Busy,
    output logic       Done
);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StExpand,
        StSbox,
        StPermute,
        StSwap,
        StFinal,
        StDone
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] round_d;
    logic       mode_eff;

    logic       ip_d, exp_d, sbox_d, perm_d, swap_d, fp_d;
    logic       ksv_d, ksr_d, busy_d, done_d;
    logic [1:0] ksa_d;

    // Key-schedule shift count for a round; dec selects the decrypt table.
    function automatic logic [1:0] shift_amount(input logic [3:0] rnd, input logic dec);
        logic [1:0] amt;
        if (rnd == 4'd0) begin
            amt = dec ? 2'd0 : 2'd1;
        end else if (rnd == 4'd1 || rnd == 4'd8 || rnd == 4'd15) begin
            amt = 2'd1;
        end else begin
            amt = 2'd2;
        end
        return amt;
    endfunction

`ifdef DES_DECRYPT_EN
    logic mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= 1'b0;
        end else if (state_q == StIdle && Start) begin
            mode_q <= Mode;
        end
    end

    assign mode_eff = mode_q;
`else
    logic unused_mode;

    assign unused_mode = Mode;
    assign mode_eff    = 1'b0;
`endif

    // Next-state and round counter.
    always_comb begin
        state_d = state_q;
        round_d = Round;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StInit;
                    round_d = 4'd0;
                end
            end
            StInit:    state_d = StExpand;
            StExpand:  if (Expansion_Finish_Flag) state_d = StSbox;
            StSbox:    if (SBox_Finish_Flag) state_d = StPermute;
            StPermute: begin
                if (Permutation_Finish_Flag) begin
                    // The last round skips the swap.
                    state_d = (Round == 4'd15) ? StFinal : StSwap;
                end
            end
            StSwap: begin
                state_d = StExpand;
                round_d = Round + 4'd1;
            end
            StFinal:   state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output decode of the next state, so the flops track the state register.
    always_comb begin
        ip_d   = (state_d == StInit);
        exp_d  = (state_d == StExpand);
        sbox_d = (state_d == StSbox);
        perm_d = (state_d == StPermute);
        swap_d = (state_d == StSwap);
        fp_d   = (state_d == StFinal);
        done_d = (state_d == StDone);
        busy_d = (state_d != StIdle) && (state_d != StDone);
        // Shift request only on entry into EXPAND, not while it stalls.
        ksv_d  = (state_d == StExpand) && (state_q != StExpand);
        ksa_d  = ksv_d ? shift_amount(round_d, mode_eff) : 2'd0;
        ksr_d  = ksv_d & mode_eff;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= StIdle;
            Round              <= 4'd0;
            IP_Select          <= 1'b0;
            Expansion_Select   <= 1'b0;
            SBox_Select        <= 1'b0;
            Permutation_Select <= 1'b0;
            Swap_Select        <= 1'b0;
            FP_Select          <= 1'b0;
            Key_Shift_Valid    <= 1'b0;
            Key_Shift_Amount   <= 2'd0;
            Key_Shift_Right    <= 1'b0;
            Busy               <= 1'b0;
            Done               <= 1'b0;
        end else begin
            state_q            <= state_d;
            Round              <= round_d;
            IP_Select          <= ip_d;
            Expansion_Select   <= exp_d;
            SBox_Select        <= sbox_d;
            Permutation_Select <= perm_d;
            Swap_Select        <= swap_d;
            FP_Select          <= fp_d;
            Key_Shift_Valid    <= ksv_d;
            Key_Shift_Amount   <= ksa_d;
            Key_Shift_Right    <= ksr_d;
            Busy               <= busy_d;
            Done               <= done_d;
        end
    end

endmodule

// File: tb/tb_des_round_controller.sv
// tb_des_round_controller
//
// Scoreboard bench for des_round_controller. Each run computes its expected
// event timeline (IP, key shifts, swaps, FP, Done) from the round schedule
// and per-stage latencies and queues it; a monitor pops one entry whenever
// the DUT shows an event and compares kind, cycle, round and shift data.
// A stage model answers each select with its finish flag after a chosen
// latency and may inject stray flags while its select is low.
// No ports.

module tb_des_round_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       Start;
    logic       Mode;
    logic       Expansion_Finish_Flag;
    logic       SBox_Finish_Flag;
    logic       Permutation_Finish_Flag;
    logic       IP_Select;
    logic       Expansion_Select;
    logic       SBox_Select;
    logic       Permutation_Select;
    logic       Swap_Select;
    logic       FP_Select;
    logic [3:0] Round;
    logic       Key_Shift_Valid;
    logic [1:0] Key_Shift_Amount;
    logic       Key_Shift_Right;
    logic       Busy;
    logic       Done;

    des_round_controller dut (
        .clk                     (clk),
        .rst                     (rst),
        .Start                   (Start),
        .Mode                    (Mode),
        .Expansion_Finish_Flag   (Expansion_Finish_Flag),
        .SBox_Finish_Flag        (SBox_Finish_Flag),
        .Permutation_Finish_Flag (Permutation_Finish_Flag),
        .IP_Select               (IP_Select),
        .Expansion_Select        (Expansion_Select),
        .SBox_Select             (SBox_Select),
        .Permutation_Select      (Permutation_Select),
        .Swap_Select             (Swap_Select),
        .FP_Select               (FP_Select),
        .Round                   (Round),
        .Key_Shift_Valid         (Key_Shift_Valid),
        .Key_Shift_Amount        (Key_Shift_Amount),
        .Key_Shift_Right         (Key_Shift_Right),
        .Busy                    (Busy),
        .Done                    (Done)
    );

    always #5 clk = ~clk;

    // Cycle n is the period that ends with posedge number n (0-based).
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int kind;   // 0 IP, 1 key shift, 2 swap, 3 FP, 4 Done
        int cyc;
        int rnd;
        int amt;
        int right;
    } ev_t;

    ev_t exp_q[$];

    int  dly[16][3];        // stage latency per round: 0 expand, 1 sbox, 2 permute
    bit  noise_en = 1'b0;
    bit  mon_en   = 1'b0;
    logic stray_sbox = 1'b0;
    int  busy_lo = 1;
    int  busy_hi = 0;

    // ---------------- stage model ----------------
    logic [2:0] fl = 3'b000;
    logic [2:0] prev_sel = 3'b000;
    int cnt[3] = '{0, 0, 0};
    int occ[3] = '{0, 0, 0};

    always @(posedge clk) begin
        logic [2:0] sel;
        #1;
        sel = {Permutation_Select, SBox_Select, Expansion_Select};
        if (IP_Select) begin
            for (int k = 0; k < 3; k++) occ[k] = 0;
        end
        for (int k = 0; k < 3; k++) begin
            if (sel[k]) begin
                cnt[k] = cnt[k] + 1;
                fl[k]  = (cnt[k] > dly[occ[k]][k]);
            end else begin
                if (prev_sel[k] && occ[k] < 15) occ[k] = occ[k] + 1;
                cnt[k] = 0;
                fl[k]  = noise_en && ($urandom_range(7) == 0);
            end
        end
        prev_sel = sel;
    end

    assign Expansion_Finish_Flag   = fl[0];
    assign SBox_Finish_Flag        = fl[1] | stray_sbox;
    assign Permutation_Finish_Flag = fl[2];

    // ---------------- reference schedule ----------------
    function automatic int exp_amt(input int r, input bit m);
`ifdef DES_DECRYPT_EN
        if (m && r == 0) return 0;
`endif
        if (r == 0 || r == 1 || r == 8 || r == 15) return 1;
        return 2;
    endfunction

    function automatic int exp_right(input bit m);
`ifdef DES_DECRYPT_EN
        return int'(m);
`else
        return 0;
`endif
    endfunction

    task automatic push(input int kind, input int c, input int r, input int a, input int rt);
        ev_t e;
        e.kind = kind; e.cyc = c; e.rnd = r; e.amt = a; e.right = rt;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] out_vec();
        return {IP_Select, Expansion_Select, SBox_Select, Permutation_Select, Swap_Select,
                FP_Select, Round, Key_Shift_Valid, Key_Shift_Amount, Key_Shift_Right,
                Busy, Done};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        ev_t a, e;
        if (mon_en) begin
            check("one_select", int'($countones({IP_Select, Expansion_Select, SBox_Select,
                  Permutation_Select, Swap_Select, FP_Select}) <= 1), 1);
            check("busy", int'(Busy), int'(cyc >= busy_lo && cyc <= busy_hi));
            if (IP_Select || Key_Shift_Valid || Swap_Select || FP_Select || Done) begin
                a.kind  = IP_Select ? 0 : Key_Shift_Valid ? 1 : Swap_Select ? 2 :
                          FP_Select ? 3 : 4;
                a.cyc   = cyc;
                a.rnd   = int'(Round);
                a.amt   = Key_Shift_Valid ? int'(Key_Shift_Amount) : 0;
                a.right = Key_Shift_Valid ? int'(Key_Shift_Right) : 0;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event: kind=%0d cycle=%0d round=%0d, none expected",
                             a.kind, a.cyc, a.rnd);
                end else begin
                    e = exp_q.pop_front();
                    if (a.kind != e.kind || a.cyc != e.cyc || a.rnd != e.rnd ||
                        a.amt != e.amt || a.right != e.right) begin
                        failures++;
                        $display("FAIL event: got kind=%0d cycle=%0d round=%0d amt=%0d right=%0d, expected kind=%0d cycle=%0d round=%0d amt=%0d right=%0d",
                                 a.kind, a.cyc, a.rnd, a.amt, a.right,
                                 e.kind, e.cyc, e.rnd, e.amt, e.right);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_delays(input bit randomize_it);
        for (int r = 0; r < 16; r++) begin
            for (int k = 0; k < 3; k++) begin
                dly[r][k] = randomize_it ? int'($urandom_range(4, 1)) : 1;
            end
        end
    endtask

    // Called at a negedge while the DUT is idle; Start is sampled at the
    // closing edge of this cycle. abort_rnd >= 0 resets in that round's first
    // EXPAND cycle; pulse_off > 0 repeats Start that many cycles later.
    task automatic run_des(input bit mode, input int abort_rnd, input int pulse_off);
        int s, t, t_abort, end_c;
        s       = cyc;
        t_abort = -1;
        push(0, s + 1, 0, 0, 0);
        t = s + 2;
        for (int r = 0; r < 16; r++) begin
            push(1, t, r, exp_amt(r, mode), exp_right(mode));
            if (r == abort_rnd) begin
                t_abort = t;
                break;
            end
            t = t + (dly[r][0] + 1) + (dly[r][1] + 1) + (dly[r][2] + 1);
            if (r < 15) begin
                push(2, t, r, 0, 0);
                t = t + 1;
            end
        end
        busy_lo = s + 1;
        if (t_abort < 0) begin
            push(3, t, 15, 0, 0);
            push(4, t + 1, 15, 0, 0);
            busy_hi = t;
            end_c   = t + 1;
        end else begin
            busy_hi = t_abort;
            end_c   = t_abort;
        end

        Start = 1'b1;
        Mode  = mode;
        for (int c = s + 1; c <= end_c; c++) begin
            @(negedge clk);
            Start = (c == s + pulse_off);
            Mode  = 1'($urandom_range(1));
            if (c == t_abort) begin
                rst        = 1'b1;
                Start      = 1'b1;
                stray_sbox = 1'b1;
            end
        end
        @(negedge clk);
        Start = 1'b0;
        if (t_abort >= 0) begin
            rst        = 1'b0;
            stray_sbox = 1'b0;
            check("abort_outputs_zero", int'(out_vec()), 0);
            repeat (20) @(negedge clk);
        end
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        Start = 1'b0;
        Mode  = 1'b0;
        set_delays(1'b0);
        repeat (3) @(negedge clk);
        check("reset_outputs_zero", int'(out_vec()), 0);
        rst    = 1'b0;
        @(negedge clk);
        check("idle_outputs_zero", int'(out_vec()), 0);
        mon_en = 1'b1;

        // Compliant stages, encrypt then decrypt, back to back.
        run_des(1'b0, -1, 0);
        run_des(1'b1, -1, 0);

        // Slow permutation in round 3.
        dly[3][2] = 5;
        run_des(1'b0, -1, 0);
        set_delays(1'b0);

        // Reset in round 7 with Start high and a stray S-box flag, then a full run.
        run_des(1'b1, 7, 0);
        run_des(1'b0, -1, 0);

        // Start repeated mid-run must be ignored.
        run_des(1'b0, -1, 50);

        // Randomized latencies, stray flags, mode and repeated Start.
        noise_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_delays(1'b1);
            run_des(1'($urandom_range(1)), -1,
                    ($urandom_range(1) == 1) ? int'($urandom_range(110, 1)) : 0);
            repeat ($urandom_range(3)) @(negedge clk);
        end
        noise_en = 1'b0;

        repeat (5) @(negedge clk);
        check("pending_events", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
